// File: rtl/dnn2ami_rd_path.sv
// AMI request record shared with the memory arbiter.
package dnn2ami_pkg;
    typedef struct packed {
        logic        valid;
        logic        isWrite;
        logic [63:0] addr;
        logic [63:0] data;
        logic [7:0]  size;
    } AMIRequest;
endpackage

// Show-ahead FIFO: head visible the cycle after push; push ignored when full, pop ignored when empty.
module dnn2ami_fifo #(
    parameter int W         = 8,
    parameter int LOG_DEPTH = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] pop_dat,
    output logic         full,
    output logic         empty
);
    localparam int DEPTH = 1 << LOG_DEPTH;

    logic [W-1:0]         mem [DEPTH];
    logic [LOG_DEPTH-1:0] wr_ptr;
    logic [LOG_DEPTH-1:0] rd_ptr;
    logic [LOG_DEPTH:0]   count;
    logic                 do_push;
    logic                 do_pop;

    assign full    = (count == (LOG_DEPTH+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + LOG_DEPTH'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + LOG_DEPTH'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + (LOG_DEPTH+1)'(1);
            end else if (!do_push && do_pop) begin
                count <= count - (LOG_DEPTH+1)'(1);
            end
        end
    end
endmodule

// Fractures macro reads into 8-byte AMI reads and steers in-order responses to PU input buffers.
// reqValid two cycles after an idle accept; responses stall on a full head-of-line buffer.
module dnn2ami_rd_path
    import dnn2ami_pkg::*;
#(
    parameter int NUM_PU            = 2,
    parameter int AXI_ADDR_WIDTH    = 32,
    parameter int AXI_DATA_WIDTH    = 64,
    parameter int TX_SIZE_WIDTH     = 10,
    parameter int NUM_PU_W          = $clog2(NUM_PU) + 1,
    parameter int MACRO_Q_LOG_DEPTH = 3,
    parameter int MAX_OUTSTANDING   = 16,
    parameter int INBUF_DATA_W      = NUM_PU * AXI_DATA_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rd_req,
    input  logic [NUM_PU_W-1:0]       rd_pu_id,
    input  logic [TX_SIZE_WIDTH-1:0]  rd_req_size,
    input  logic [AXI_ADDR_WIDTH-1:0] rd_addr,
    output logic                      rd_ready,
    output logic                      rd_done,
    output logic                      reqValid,
    output AMIRequest                 reqOut,
    input  logic                      reqOut_grant,
    input  logic                      respValid,
    input  logic [AXI_DATA_WIDTH-1:0] respData,
    output logic                      resp_grant,
    input  logic [NUM_PU-1:0]         inbuf_full,
    output logic [NUM_PU-1:0]         inbuf_push,
    output logic [INBUF_DATA_W-1:0]   data_to_inbuf
);
    localparam int MACRO_W = NUM_PU_W + TX_SIZE_WIDTH + AXI_ADDR_WIDTH;
    localparam int TAG_W   = NUM_PU_W + 1;
    localparam int TAG_LOG = $clog2(MAX_OUTSTANDING);
    localparam int OUT_W   = TAG_LOG + 1;

    typedef enum logic {IDLE, ISSUE} state_t;

    logic                      macro_push;
    logic                      macro_pop;
    logic                      macro_full;
    logic                      macro_empty;
    logic [MACRO_W-1:0]        macro_dat;
    logic [NUM_PU_W-1:0]       m_pu;
    logic [TX_SIZE_WIDTH-1:0]  m_size;
    logic [AXI_ADDR_WIDTH-1:0] m_addr;

    state_t                    state;
    logic [AXI_ADDR_WIDTH-1:0] cur_addr;
    logic [TX_SIZE_WIDTH-1:0]  beats_left;
    logic [NUM_PU_W-1:0]       cur_pu;
    logic [OUT_W-1:0]          outstanding;
    logic                      req_fire;

    logic                      tag_full;
    logic                      tag_empty;
    logic [TAG_W-1:0]          tag_dat;
    logic [NUM_PU_W-1:0]       head_pu;
    logic                      head_last;
    logic                      head_blocked;

    // Zero-length requests never enter the queue, so the FSM only ever sees non-empty work.
    assign macro_push = rd_req && (rd_req_size != '0);
    assign rd_ready   = !macro_full;
    assign macro_pop  = (state == IDLE) && !macro_empty;
    assign {m_pu, m_size, m_addr} = macro_dat;

    dnn2ami_fifo #(
        .W         (MACRO_W),
        .LOG_DEPTH (MACRO_Q_LOG_DEPTH)
    ) u_macro_q (
        .clk      (clk),
        .rst      (rst),
        .push     (macro_push),
        .push_dat ({rd_pu_id, rd_req_size, rd_addr}),
        .pop      (macro_pop),
        .pop_dat  (macro_dat),
        .full     (macro_full),
        .empty    (macro_empty)
    );

    assign reqValid = (state == ISSUE) && (outstanding < OUT_W'(MAX_OUTSTANDING)) && !tag_full;
    assign req_fire = reqValid && reqOut_grant;

    always_comb begin
        reqOut         = '0;
        reqOut.valid   = 1'b1;
        reqOut.isWrite = 1'b0;
        reqOut.addr    = 64'(cur_addr);
        reqOut.size    = 8'd8;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cur_addr   <= '0;
            beats_left <= '0;
            cur_pu     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!macro_empty) begin
                        cur_addr   <= m_addr;
                        beats_left <= m_size;
                        cur_pu     <= m_pu;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (req_fire) begin
                        cur_addr   <= cur_addr + AXI_ADDR_WIDTH'(8);
                        beats_left <= beats_left - TX_SIZE_WIDTH'(1);
                        if (beats_left == TX_SIZE_WIDTH'(1)) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding <= '0;
        end else if (req_fire && !resp_grant) begin
            outstanding <= outstanding + OUT_W'(1);
        end else if (!req_fire && resp_grant) begin
            outstanding <= outstanding - OUT_W'(1);
        end
    end

    // One tag per granted read; responses return in order, so the head names the destination.
    dnn2ami_fifo #(
        .W         (TAG_W),
        .LOG_DEPTH (TAG_LOG)
    ) u_tag_q (
        .clk      (clk),
        .rst      (rst),
        .push     (req_fire),
        .push_dat ({cur_pu, beats_left == TX_SIZE_WIDTH'(1)}),
        .pop      (resp_grant),
        .pop_dat  (tag_dat),
        .full     (tag_full),
        .empty    (tag_empty)
    );

    assign {head_pu, head_last} = tag_dat;

    always_comb begin
        head_blocked = 1'b0;
        for (int i = 0; i < NUM_PU; i++) begin
            if (head_pu == NUM_PU_W'(i)) begin
                head_blocked = inbuf_full[i];
            end
        end
    end

    assign resp_grant = respValid && !tag_empty && !head_blocked;

    always_comb begin
        inbuf_push    = '0;
        data_to_inbuf = '0;
        for (int i = 0; i < NUM_PU; i++) begin
            if (!tag_empty && (head_pu == NUM_PU_W'(i))) begin
                inbuf_push[i] = resp_grant;
                data_to_inbuf[i*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] = respData;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_done <= 1'b0;
        end else begin
            rd_done <= resp_grant && head_last;
        end
    end
endmodule

// File: tb/tb_dnn2ami_rd_path.sv
// Scoreboard bench: stimulus pushes expected AMI reads and PU pushes; monitor pops and compares.
module tb_dnn2ami_rd_path;
    import dnn2ami_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         rd_req;
    logic [1:0]   rd_pu_id;
    logic [9:0]   rd_req_size;
    logic [31:0]  rd_addr;
    logic         rd_ready;
    logic         rd_done;
    logic         reqValid;
    AMIRequest    reqOut;
    logic         reqOut_grant;
    logic         respValid;
    logic [63:0]  respData;
    logic         resp_grant;
    logic [1:0]   inbuf_full;
    logic [1:0]   inbuf_push;
    logic [127:0] data_to_inbuf;

    dnn2ami_rd_path dut (
        .clk           (clk),
        .rst           (rst),
        .rd_req        (rd_req),
        .rd_pu_id      (rd_pu_id),
        .rd_req_size   (rd_req_size),
        .rd_addr       (rd_addr),
        .rd_ready      (rd_ready),
        .rd_done       (rd_done),
        .reqValid      (reqValid),
        .reqOut        (reqOut),
        .reqOut_grant  (reqOut_grant),
        .respValid     (respValid),
        .respData      (respData),
        .resp_grant    (resp_grant),
        .inbuf_full    (inbuf_full),
        .inbuf_push    (inbuf_push),
        .data_to_inbuf (data_to_inbuf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] exp_addr[$];
    logic [1:0]  exp_pu[$];
    logic [63:0] exp_dat[$];
    bit          exp_last[$];
    logic [63:0] pend_dat[$];
    int          pend_rdy[$];

    int n_checks = 0, n_fail = 0;
    int n_grant = 0, n_push = 0, n_done = 0;
    int budget = 1000000;
    bit force_resp = 1'b0;
    bit done_exp = 1'b0;
    bit mon_next;
    logic [1:0]  mon_pu;
    logic [63:0] mon_dat;

    function automatic logic [63:0] memdata(input logic [31:0] a);
        return {a ^ 32'h0F0F_0000, ~a};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every granted read and every PU push is matched against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                done_exp = 1'b0;
            end else begin
                if (done_exp || rd_done) chk("rd_done", rd_done, done_exp);
                if (rd_done) n_done++;
                mon_next = 1'b0;
                if (reqValid && reqOut_grant) begin
                    n_grant++;
                    if (exp_addr.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL req_unexpected: got grant at 0x%0h, expected none", reqOut.addr);
                    end else begin
                        chk("req_addr", reqOut.addr, {32'h0, exp_addr.pop_front()});
                        chk("req_fields", {reqOut.valid, reqOut.isWrite, reqOut.data, reqOut.size},
                            {1'b1, 1'b0, 64'h0, 8'h08});
                    end
                end
                if (inbuf_push != 2'b00) begin
                    n_push++;
                    if (exp_pu.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL push_unexpected: got push 0x%0h, expected none", inbuf_push);
                    end else begin
                        mon_pu   = exp_pu.pop_front();
                        mon_dat  = exp_dat.pop_front();
                        mon_next = exp_last.pop_front();
                        chk("push_strobe", inbuf_push, 128'(2'b01 << mon_pu));
                        chk("push_data", data_to_inbuf, 128'(mon_dat) << (64 * mon_pu));
                    end
                end
                done_exp = mon_next;
            end
        end
    end

    // Memory model: answers each granted read in order, three cycles after its grant.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && reqValid && reqOut_grant) begin
                pend_dat.push_back(memdata(reqOut.addr[31:0]));
                pend_rdy.push_back(cyc + 3);
            end
            if (!rst && resp_grant && !force_resp && pend_dat.size() > 0) begin
                void'(pend_dat.pop_front());
                void'(pend_rdy.pop_front());
                budget--;
            end
        end
    end

    initial begin
        respValid = 1'b0;
        respData  = '0;
        forever begin
            @(posedge clk);
            #2;
            if (force_resp) begin
                respValid = 1'b1;
                respData  = 64'hBAD0_BAD0_BAD0_BAD0;
            end else if (budget > 0 && pend_dat.size() > 0 && pend_rdy[0] <= cyc) begin
                respValid = 1'b1;
                respData  = pend_dat[0];
            end else begin
                respValid = 1'b0;
                respData  = '0;
            end
        end
    end

    task automatic expect_beat(input logic [1:0] pu, input logic [31:0] a, input bit last);
        exp_addr.push_back(a);
        exp_pu.push_back(pu);
        exp_dat.push_back(memdata(a));
        exp_last.push_back(last);
    endtask

    task automatic expect_macro(input logic [1:0] pu, input int size, input logic [31:0] base);
        for (int b = 0; b < size; b++) expect_beat(pu, base + 32'(b * 8), b == size - 1);
    endtask

    task automatic send(input logic [1:0] pu, input logic [9:0] sz, input logic [31:0] a, output bit acc);
        rd_req = 1'b1; rd_pu_id = pu; rd_req_size = sz; rd_addr = a;
        acc = rd_ready;
        @(posedge clk); #1;
        rd_req = 1'b0;
    endtask

    task automatic drain(input string nm);
        int k;
        k = 0;
        while ((exp_addr.size() != 0 || exp_pu.size() != 0 || done_exp) && k < 400) begin
            @(posedge clk); #1;
            k++;
        end
        repeat (2) begin @(posedge clk); #1; end
        chk({nm, "_drain"}, 128'(k < 400), 128'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int d0, g0, p0, k;
        rst = 1'b1; rd_req = 1'b0; rd_pu_id = '0; rd_req_size = '0; rd_addr = '0;
        reqOut_grant = 1'b1; inbuf_full = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rd_ready", rd_ready, 1);
        chk("rst_reqValid", reqValid, 0);
        chk("rst_resp_grant", resp_grant, 0);
        chk("rst_inbuf_push", inbuf_push, 0);
        chk("rst_rd_done", rd_done, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Single 4-beat macro, latency and address sequence
        expect_beat(2'd0, 32'h0000_1000, 1'b0);
        expect_beat(2'd0, 32'h0000_1008, 1'b0);
        expect_beat(2'd0, 32'h0000_1010, 1'b0);
        expect_beat(2'd0, 32'h0000_1018, 1'b1);
        d0 = n_done;
        send(2'd0, 10'd4, 32'h0000_1000, acc);
        chk("t1_accept", acc, 1);
        @(negedge clk);
        chk("t1_lat_n1", reqValid, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t1_lat_n2", reqValid, 1);
        @(posedge clk); #1;
        drain("t1");
        chk("t1_done_cnt", n_done - d0, 1);

        // Outstanding limit: 20 beats, responses withheld
        g0 = n_grant; p0 = n_push; budget = 0;
        expect_macro(2'd0, 20, 32'h0000_8000);
        send(2'd0, 10'd20, 32'h0000_8000, acc);
        repeat (30) begin @(posedge clk); #1; end
        chk("t2_grants16", n_grant - g0, 16);
        @(negedge clk);
        chk("t2_stall16", reqValid, 0);
        @(posedge clk); #1;
        budget = 1;
        repeat (10) begin @(posedge clk); #1; end
        chk("t2_grants17", n_grant - g0, 17);
        @(negedge clk);
        chk("t2_stall17", reqValid, 0);
        @(posedge clk); #1;
        budget = 1000000;
        drain("t2");
        chk("t2_grants20", n_grant - g0, 20);
        chk("t2_pushes20", n_push - p0, 20);

        // Full PU1 buffer blocks responses
        inbuf_full = 2'b10;
        expect_macro(2'd1, 4, 32'h0000_3000);
        send(2'd1, 10'd4, 32'h0000_3000, acc);
        k = 0;
        do begin @(negedge clk); k++; end while (!respValid && k < 30);
        chk("t3_resp_seen", respValid, 1);
        for (int i = 0; i < 10; i++) begin
            chk("t3_hold_grant", resp_grant, 0);
            chk("t3_hold_push", inbuf_push, 0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        inbuf_full = 2'b00;
        drain("t3");

        // Two queued macros to different PUs deliver in issue order
        d0 = n_done;
        expect_macro(2'd0, 2, 32'h0000_0000);
        expect_macro(2'd1, 3, 32'h0000_2000);
        send(2'd0, 10'd2, 32'h0000_0000, acc);
        send(2'd1, 10'd3, 32'h0000_2000, acc);
        drain("t4");
        chk("t4_done_cnt", n_done - d0, 2);

        // Macro queue fill with arbiter stalled; 9th request dropped
        reqOut_grant = 1'b0;
        expect_macro(2'd0, 1, 32'h0000_5000);
        send(2'd0, 10'd1, 32'h0000_5000, acc);
        repeat (3) begin @(posedge clk); #1; end
        for (int i = 0; i < 8; i++) begin
            expect_macro(2'(i % 2), 1, 32'h0000_5100 + 32'(i * 256));
            send(2'(i % 2), 10'd1, 32'h0000_5100 + 32'(i * 256), acc);
            chk("t5_acc", acc, 1);
        end
        chk("t5_full", rd_ready, 0);
        send(2'd0, 10'd1, 32'h0000_9900, acc);
        chk("t5_drop", acc, 0);
        reqOut_grant = 1'b1;
        drain("t5");
        d0 = n_done; g0 = n_grant;
        send(2'd0, 10'd0, 32'h0000_7000, acc);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("t5_zero_valid", reqValid, 0);
            @(posedge clk); #1;
        end
        chk("t5_zero_done", n_done - d0, 0);
        chk("t5_zero_grant", n_grant - g0, 0);

        // Reset with 5 reads outstanding
        g0 = n_grant; budget = 0;
        expect_macro(2'd0, 8, 32'h0000_4000);
        send(2'd0, 10'd8, 32'h0000_4000, acc);
        k = 0;
        while (n_grant - g0 < 5 && k < 50) begin @(posedge clk); #1; k++; end
        reqOut_grant = 1'b0;
        chk("t6_out5", n_grant - g0, 5);
        @(negedge clk);
        chk("t6_pre_valid", reqValid, 1);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("t6_rst_reqValid", reqValid, 0);
        chk("t6_rst_resp_grant", resp_grant, 0);
        chk("t6_rst_push", inbuf_push, 0);
        chk("t6_rst_done", rd_done, 0);
        chk("t6_rst_ready", rd_ready, 1);
        exp_addr.delete(); exp_pu.delete(); exp_dat.delete(); exp_last.delete();
        pend_dat.delete(); pend_rdy.delete();
        budget = 1000000;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; reqOut_grant = 1'b1; force_resp = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t6_stray_grant", resp_grant, 0);
            chk("t6_stray_push", inbuf_push, 0);
            chk("t6_idle_valid", reqValid, 0);
        end
        @(posedge clk); #1;
        force_resp = 1'b0;
        @(posedge clk); #1;

        // Address wrap at the top of the 32-bit space
        d0 = n_done;
        expect_beat(2'd1, 32'hFFFF_FFF8, 1'b0);
        expect_beat(2'd1, 32'h0000_0000, 1'b1);
        send(2'd1, 10'd2, 32'hFFFF_FFF8, acc);
        drain("t6_wrap");
        chk("t6_wrap_done", n_done - d0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
